// File: rtl/lcd_pkg.sv
// Shared types, power-up command table and command helpers for the HD44780 write scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } state_t;

  // Function set 8-bit/2-line, display on, entry mode increment, clear.
  localparam logic [0:3][7:0] INIT_TABLE = {8'h38, 8'h0C, 8'h06, 8'h01};

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;
  localparam logic [7:0] LCD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_LINE2 = 8'hC0;

  // Clear and return-home (03 decodes as home too) need the long execution time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] cmd);
    return !rs && (cmd == LCD_CLEAR || cmd == LCD_HOME || cmd == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way grant for the LCD requesters; round-robin by default,
// fixed priority for requester 0 when LCD_FIXED_PRIORITY_EN is defined.
module lcd_rr_arbiter (
`ifndef LCD_FIXED_PRIORITY_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef LCD_FIXED_PRIORITY_EN
  always_comb begin
    grant = 2'b00;
    if (enable) grant = req[0] ? 2'b01 : {req[1], 1'b0};
  end
`else
  logic prio;  // requester that wins a tie

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  // Any grant is a transfer, so a withdrawn request never moves the pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                prio <= 1'b0;
    else if (grant != 2'b00) prio <= grant[0];
  end
`endif

endmodule

// File: rtl/lcd_write_scheduler.sv
// HD44780 bus owner: power-up init sequence, then timed byte writes shared by two requesters.
// Build option: LCD_FIXED_PRIORITY_EN gives requester 0 fixed priority instead of round-robin.
//
// state | meaning
// PWRUP | idle after reset, waiting for the LCD to power up
// SETUP | rs/data driven, en low
// PULSE | en high
// HOLD  | en low, rs/data held
// WAIT  | LCD execution time (long for clear/home)
// IDLE  | init done, accepting requester bytes
module lcd_write_scheduler
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_rs,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int T_M0  = (T_PWRUP_CYC > T_CLR_CYC)  ? T_PWRUP_CYC : T_CLR_CYC;
  localparam int T_M1  = (T_CMD_CYC   > T_EN_CYC)   ? T_CMD_CYC   : T_EN_CYC;
  localparam int T_M2  = (T_SETUP_CYC > T_HOLD_CYC) ? T_SETUP_CYC : T_HOLD_CYC;
  localparam int T_M3  = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int T_MAX = (T_M0 > T_M3) ? T_M0 : T_M3;
  localparam int CW    = $clog2(T_MAX) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    init_idx;
  logic [1:0]    grant;
  logic          arb_en;

  assign lcd_rw    = 1'b0;
  assign busy      = (state != ST_IDLE);
  assign arb_en    = (state == ST_IDLE) && init_done;
  assign req_ready = grant;

  lcd_rr_arbiter u_arb (
`ifndef LCD_FIXED_PRIORITY_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .enable (arb_en),
    .req    (req_valid),
    .grant  (grant)
  );

  // Counter is loaded with duration-1 on each state entry; a state ends when it reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_PWRUP;
      cnt       <= CW'(T_PWRUP_CYC - 1);
      init_idx  <= 2'd0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      case (state)
        ST_PWRUP: begin
          if (cnt == '0) begin
            state    <= ST_SETUP;
            cnt      <= CW'(T_SETUP_CYC - 1);
            lcd_rs   <= 1'b0;
            lcd_data <= INIT_TABLE[0];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state  <= ST_PULSE;
            cnt    <= CW'(T_EN_CYC - 1);
            lcd_en <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            state  <= ST_HOLD;
            cnt    <= CW'(T_HOLD_CYC - 1);
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_WAIT;
            cnt   <= is_slow_cmd(lcd_rs, lcd_data) ? CW'(T_CLR_CYC - 1) : CW'(T_CMD_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (init_done) begin
            state <= ST_IDLE;
          end else if (init_idx == 2'd3) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end else begin
            state    <= ST_SETUP;
            cnt      <= CW'(T_SETUP_CYC - 1);
            init_idx <= init_idx + 2'd1;
            lcd_rs   <= 1'b0;
            lcd_data <= INIT_TABLE[init_idx + 2'd1];
          end
        end
        ST_IDLE: begin
          if (grant != 2'b00) begin
            state    <= ST_SETUP;
            cnt      <= CW'(T_SETUP_CYC - 1);
            lcd_rs   <= grant[1] ? req_rs[1] : req_rs[0];
            lcd_data <= grant[1] ? req_data1 : req_data0;
          end
        end
        default: begin
          state <= ST_PWRUP;
          cnt   <= CW'(T_PWRUP_CYC - 1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Scoreboard bench for lcd_write_scheduler with shortened timing (PWRUP=10 SETUP=2 EN=3 HOLD=2 CMD=5 CLR=20).
module tb_lcd_write_scheduler;

  typedef struct {
    logic [1:0] grant;
    logic       rs;
    logic [7:0] data;
    int         wt;
  } hs_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } pulse_t;

  localparam logic [0:3][7:0] INIT_SEQ = {8'h38, 8'h0C, 8'h06, 8'h01};

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_rs;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       init_done;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  int n_vec = 0;
  int n_bad = 0;

  hs_t    hs_q[$];
  pulse_t pulse_q[$];

  lcd_write_scheduler #(
    .T_PWRUP_CYC (10),
    .T_SETUP_CYC (2),
    .T_EN_CYC    (3),
    .T_HOLD_CYC  (2),
    .T_CMD_CYC   (5),
    .T_CLR_CYC   (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .init_done (init_done),
    .busy      (busy),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pulse(input logic rs_v, input logic [7:0] d);
    pulse_t p;
    p.rs   = rs_v;
    p.data = d;
    pulse_q.push_back(p);
  endtask

  task automatic expect_xfer(input int i, input logic rs_v, input logic [7:0] d, input int w);
    hs_t e;
    e.grant = (i == 1) ? 2'b10 : 2'b01;
    e.rs    = rs_v;
    e.data  = d;
    e.wt    = w;
    hs_q.push_back(e);
    expect_pulse(rs_v, d);
  endtask

  // Releases reset, checks power-up/init timing; both requesters are held so the
  // first transfer (requester 0) happens the cycle init_done rises.
  task automatic run_init(input logic [7:0] d0);
    int k = 0;
    int first_en = -1;
    int done_at = -1;
    int bad_ready = 0;
    for (int j = 0; j < 4; j++) expect_pulse(1'b0, INIT_SEQ[j]);
    expect_xfer(0, 1'b1, d0, 5);
    req_rs    = 2'b01;
    req_data0 = d0;
    req_data1 = 8'hC0;
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    while (done_at < 0 && k < 300) begin
      #1;
      if (lcd_en && first_en < 0) first_en = k;
      if (init_done) done_at = k;
      else if (req_ready != 2'b00) bad_ready++;
      if (done_at < 0) begin
        @(negedge clk);
        k++;
      end
    end
    chk("init_first_en_cycle", first_en, 12);
    chk("init_done_cycle", done_at, 73);
    chk("init_ready_low", bad_ready, 0);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic send(input int i, input logic rs_v, input logic [7:0] d, input int w);
    int guard = 0;
    expect_xfer(i, rs_v, d, w);
    @(negedge clk);
    req_rs[i] = rs_v;
    if (i == 0) req_data0 = d;
    else        req_data1 = d;
    req_valid[i] = 1'b1;
    #1;
    while (!req_ready[i] && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("send_ready_seen", req_ready[i], 1'b1);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic hold_both(input int n);
    int seen = 0;
    int guard = 0;
    @(negedge clk);
    req_rs    = 2'b01;
    req_data0 = 8'h42;
    req_data1 = 8'hC0;
    req_valid = 2'b11;
    while (seen < n && guard < 2000) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) seen++;
      @(negedge clk);
      guard++;
    end
    req_valid = 2'b00;
    chk("hold_both_count", seen, n);
  endtask

  // Handshake monitor: grant, bus values at H+1, setup, enable width and next-ready latency.
  initial begin : hs_mon
    hs_t e;
    bit  fresh = 0;
    bit  aborted;
    int  k, rise, fall, idle;
    forever begin
      if (!fresh) begin
        @(negedge clk);
        #1;
      end
      fresh = 0;
      if (rst && (req_valid & req_ready) != 2'b00) begin
        if (hs_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL hs_unexpected: got grant %b, want none at %0t", req_ready, $time);
        end else begin
          e = hs_q.pop_front();
          chk("hs_grant", req_ready, e.grant);
          k = 0; rise = -1; fall = -1; idle = -1; aborted = 0;
          while (idle < 0 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
            if (!rst) begin
              aborted = 1;
              break;
            end
            if (k == 1) begin
              chk("hs_lcd_rs", lcd_rs, e.rs);
              chk("hs_lcd_data", lcd_data, e.data);
            end
            if (lcd_en && rise < 0) rise = k;
            if (!lcd_en && rise >= 0 && fall < 0) fall = k;
            if (!busy) idle = k;
          end
          if (!aborted) begin
            chk("hs_setup_cycles", rise, 3);
            chk("hs_en_width", fall - rise, 3);
            chk("hs_next_ready", idle, 8 + e.wt);
            fresh = (idle >= 0);
          end
        end
      end
    end
  end

  // Bus monitor: every enable pulse must carry the next expected byte.
  initial begin : bus_mon
    pulse_t p;
    logic   en_prev = 1'b0;
    int     w;
    forever begin
      @(negedge clk);
      #1;
      if (rst && lcd_en && !en_prev) begin
        if (pulse_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL pulse_unexpected: got rs=%b data=0x%0h, want none", lcd_rs, lcd_data);
        end else begin
          p = pulse_q.pop_front();
          chk("pulse_rs", lcd_rs, p.rs);
          chk("pulse_data", lcd_data, p.data);
          chk("pulse_rw", lcd_rw, 1'b0);
        end
        w = 0;
        while (lcd_en && rst && w < 50) begin
          w++;
          @(negedge clk);
          #1;
        end
        if (rst) chk("pulse_width", w, 3);
      end
      en_prev = lcd_en;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no end of test, want finish before 400000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int guard;
    rst       = 1'b0;
    req_valid = 2'b11;
    req_rs    = 2'b01;
    req_data0 = 8'h41;
    req_data1 = 8'hC0;
    #2;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_lcd_rs", lcd_rs, 1'b0);
    chk("rst_lcd_rw", lcd_rw, 1'b0);
    chk("rst_lcd_en", lcd_en, 1'b0);
    chk("rst_lcd_data", lcd_data, 8'h00);

    run_init(8'h41);
    // Lone request from the side the pointer does not favour; rs=1 so 01 is data.
    send(0, 1'b1, 8'h01, 5);

`ifdef LCD_FIXED_PRIORITY_EN
    for (int j = 0; j < 4; j++) expect_xfer(0, 1'b1, 8'h42, 5);
`else
    for (int j = 0; j < 2; j++) begin
      expect_xfer(1, 1'b0, 8'hC0, 5);
      expect_xfer(0, 1'b1, 8'h42, 5);
    end
`endif
    hold_both(4);

    send(1, 1'b0, 8'h01, 20);
    send(1, 1'b0, 8'h80, 5);
    send(1, 1'b0, 8'h02, 20);
    send(1, 1'b0, 8'h03, 20);
    send(1, 1'b0, 8'h04, 5);

    // Reset in the middle of an enable pulse.
    send(0, 1'b1, 8'h55, 5);
    guard = 0;
    #1;
    while (!lcd_en && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("mid_en_seen", lcd_en, 1'b1);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_lcd_en", lcd_en, 1'b0);
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_req_ready", req_ready, 2'b00);
    chk("mid_rst_lcd_data", lcd_data, 8'h00);
    chk("mid_rst_lcd_rs", lcd_rs, 1'b0);
    repeat (3) @(negedge clk);

    run_init(8'h37);
`ifdef LCD_FIXED_PRIORITY_EN
    expect_xfer(0, 1'b1, 8'h42, 5);
    expect_xfer(0, 1'b1, 8'h42, 5);
`else
    expect_xfer(1, 1'b0, 8'hC0, 5);
    expect_xfer(0, 1'b1, 8'h42, 5);
`endif
    hold_both(2);

    repeat (40) @(negedge clk);
    chk("hs_queue_drained", hs_q.size(), 0);
    chk("pulse_queue_drained", pulse_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
